voting_tally_seq: RTL and testbench
===================================

Name: voting_tally_seq

Overview:
- Streaming, parametrised successor to the combinational voting block.
- Accepts one vote per cycle over a valid/ready handshake and tallies votes for 2^N candidates.
- A frame is 2^M votes, or fewer if closed early by in_last.
- At frame end, a sequential argmax scan reports the winner, its count and a tie flag, then the block clears for the next frame.

Parameters:
- N, 1: candidate index width; there are 2^N candidates.
- M, 3: log2 of the maximum number of voters per frame.
- CW, M+1: counter width, derived and not overridable; 2^M must fit without saturation.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a vote is presented.
- in_vote  input  N  candidate index of the vote.
- in_last  input  1  this vote closes the frame early; qualified by the handshake.
- in_ready  output  1  the block accepts a vote this cycle.
- res_valid  output  1  the result is available.
- res_ready  input  1  the consumer takes the result.
- res_winner  output  N  index of the winning candidate.
- res_count  output  CW  vote count of the winner.
- res_tie  output  1  another candidate has a count equal to res_count.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to COLLECT.
  - All candidate counters, the vote counter and the scan index clear.
  - res_valid, res_winner, res_count and res_tie go to 0.
  - in_ready is 1 after reset is released.
- State COLLECT:
  - in_ready = 1 and res_valid = 0.
  - A vote is accepted when in_valid && in_ready. On acceptance, cnt[in_vote] increments and votes_seen increments.
  - If the accepted vote makes votes_seen == 2^M, or in_last = 1, the next state is SCAN.
  - Idle cycles (in_valid = 0) change nothing.
- State SCAN (in_ready = 0), running for exactly 2^N cycles with idx = 0 .. 2^N-1:
  - On idx = 0: best = cnt[0], win = 0, tie = 0.
  - On idx > 0, if cnt[idx] > best: best = cnt[idx], win = idx, tie = 0.
  - On idx > 0, if cnt[idx] == best: tie = 1 and win is unchanged, so ties resolve to the lowest index.
  - After the final idx the next state is DONE.
- State DONE:
  - res_valid = 1 and in_ready = 0.
  - res_winner, res_count and res_tie hold stable until res_valid && res_ready.
  - On that handshake: all counters clear, votes_seen clears, and the next state is COLLECT. res_valid drops on the next cycle. The result fields keep their last values but are don't-care while res_valid = 0.
  - The handshake is allowed on the first DONE cycle.
- Latency:
  - res_valid rises 2^N+1 clock edges after the edge that accepted the closing vote.
  - Throughput is one frame per (votes + 2^N + 1 + consumer wait) cycles.
- Boundary conditions:
  - in_valid while in_ready = 0 is ignored and never counted.
  - in_last on the 2^M-th vote behaves the same as reaching the full count.
  - in_last presented without in_valid has no effect.
  - A frame always contains at least one vote, so res_count >= 1.
  - Counters never exceed 2^M and are CW bits wide, so they never wrap.
  - Unanimous frame: res_count = number of votes in the frame and res_tie = 0.

Decomposition:
- Package voting_pkg:
  - state enum {COLLECT, SCAN, DONE};
  - helper function for the derived counter width CW(M) = M+1.
- Sub-module voting_tally_bank:
  - 2^N counters of CW bits each;
  - one increment port (enable plus index);
  - a synchronous clear-all;
  - one combinational read port indexed by the scan index.
- The top level holds the FSM, votes_seen, the argmax registers and the handshakes.

Test Plan:
- Majority win, N=1, M=3: 8 back-to-back votes 1,1,1,0,0,1,0,1 -> res_valid rises 3 edges after the 8th accept; res_winner=1, res_count=5, res_tie=0.
- Tie, N=1, M=3: votes 0,1,0,1,0,1,0,1 -> res_winner=0, res_count=4, res_tie=1.
- Early close, N=2, M=3: votes 2,3,2 with in_last on the 3rd -> res_valid rises 5 edges after the 3rd accept; res_winner=2, res_count=2, res_tie=0.
- Backpressure: hold res_ready=0 for 10 cycles in DONE while driving in_valid=1 -> in_ready stays 0, outputs stay stable, no votes are counted; res_ready=1 -> COLLECT on the next edge, and the next frame of 8 votes for candidate 0 gives res_count=8.
- Async reset mid-frame: 5 votes accepted, then rst pulses between clock edges -> res_valid=0 and in_ready=1 immediately; a fresh frame of 8 votes gives counts without any residue from the aborted frame.
- Bubbles: 8 votes with random in_valid gaps (50% duty) -> the result is identical to the gap-free run, and latency from the closing accept is unchanged.

Source files
------------

// File: rtl/voting_pkg.sv
// voting_pkg: shared FSM encoding and derived counter width for the voting tally.
package voting_pkg;
  typedef enum logic [1:0] {COLLECT, SCAN, DONE} state_t;
  function automatic int cw(input int m);
    return m + 1;
  endfunction
endpackage

// File: rtl/voting_tally_bank.sv
// voting_tally_bank: 2^N per-candidate vote counters with one increment port and one read port.
module voting_tally_bank #(
  parameter int N  = 1,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic [N-1:0]  i_idx,
  input  logic          i_clr,
  input  logic [N-1:0]  i_rd_idx,
  output logic [CW-1:0] o_rd_cnt
);
  logic [CW-1:0] r_cnt [2**N];
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int k = 0; k < 2**N; k++) r_cnt[k] <= '0;
    else if (i_clr)
      for (int k = 0; k < 2**N; k++) r_cnt[k] <= '0;
    else if (i_inc)
      r_cnt[i_idx] <= r_cnt[i_idx] + 1'b1;
  assign o_rd_cnt = r_cnt[i_rd_idx];
endmodule

// File: rtl/voting_tally_seq.sv
// voting_tally_seq: streaming vote tally over frames of up to 2^M votes, with a sequential argmax scan.
module voting_tally_seq
  import voting_pkg::*;
#(
  parameter int N = 1,
  parameter int M = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     in_vote,
  input  logic             in_last,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_winner,
  output logic [cw(M)-1:0] res_count,
  output logic             res_tie
);
  localparam int CW = cw(M);
  state_t        r_state;
  logic [CW-1:0] r_seen, r_best, w_rd;
  logic [N:0]    r_idx;
  logic [N-1:0]  r_win;
  logic          r_tie, w_acc, w_take, w_close;
  assign in_ready  = r_state == COLLECT;
  assign res_valid = r_state == DONE;
  assign w_acc     = in_valid && in_ready;
  assign w_take    = res_valid && res_ready;
  assign w_close   = in_last || r_seen == CW'((1 << M) - 1);
  voting_tally_bank #(.N(N), .CW(CW)) u_bank (
    .clk(clk), .rst(rst), .i_inc(w_acc), .i_idx(in_vote), .i_clr(w_take),
    .i_rd_idx(r_idx[N-1:0]), .o_rd_cnt(w_rd)
  );
  // r_idx runs one step past the last candidate; that step commits the argmax to the result ports
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= COLLECT;
      r_seen     <= '0;
      r_idx      <= '0;
      r_best     <= '0;
      r_win      <= '0;
      r_tie      <= 1'b0;
      res_winner <= '0;
      res_count  <= '0;
      res_tie    <= 1'b0;
    end else
      case (r_state)
        COLLECT: if (w_acc) begin
          r_seen <= r_seen + 1'b1;
          if (w_close) r_state <= SCAN;
        end
        SCAN: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx[N]) begin
            res_winner <= r_win;
            res_count  <= r_best;
            res_tie    <= r_tie;
            r_idx      <= '0;
            r_state    <= DONE;
          end else if (r_idx == '0) begin
            r_best <= w_rd;
            r_win  <= '0;
            r_tie  <= 1'b0;
          end else if (w_rd > r_best) begin
            r_best <= w_rd;
            r_win  <= r_idx[N-1:0];
            r_tie  <= 1'b0;
          end else if (w_rd == r_best)
            r_tie <= 1'b1;
        end
        default: if (w_take) begin
          r_seen  <= '0;
          r_state <= COLLECT;
        end
      endcase
endmodule

// File: tb/tb_voting_tally_seq.sv
// tb_voting_tally_seq: table-driven frames on an N=1 and an N=2 instance, plus backpressure and async-reset sequences.
module tb_voting_tally_seq;
  typedef struct packed {
    logic        sel;
    logic        early;
    logic        bub;
    logic [3:0]  n;
    logic [15:0] votes;
    logic [1:0]  win;
    logic [3:0]  cnt;
    logic        tie;
  } vec_t;
  logic clk = 0, rst = 1, valid = 0, last = 0, rdy = 0, sel = 0;
  logic [1:0] vote = '0;
  logic ir1, rv1, t1, ir2, rv2, t2, ir, rv, tie;
  logic [0:0] w1;
  logic [1:0] w2, win;
  logic [3:0] c1, c2, cnt;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  voting_tally_seq #(.N(1), .M(3)) d1 (
    .clk(clk), .rst(rst), .in_valid(valid && !sel), .in_vote(vote[0]), .in_last(last),
    .in_ready(ir1), .res_valid(rv1), .res_ready(rdy && !sel), .res_winner(w1),
    .res_count(c1), .res_tie(t1)
  );
  voting_tally_seq #(.N(2), .M(3)) d2 (
    .clk(clk), .rst(rst), .in_valid(valid && sel), .in_vote(vote), .in_last(last),
    .in_ready(ir2), .res_valid(rv2), .res_ready(rdy && sel), .res_winner(w2),
    .res_count(c2), .res_tie(t2)
  );
  assign ir  = sel ? ir2 : ir1;
  assign rv  = sel ? rv2 : rv1;
  assign win = sel ? w2 : {1'b0, w1};
  assign cnt = sel ? c2 : c1;
  assign tie = sel ? t2 : t1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic s, e, b, input int n, input logic [15:0] v,
                              input int w, c, input logic t);
    return {s, e, b, 4'(n), v, 2'(w), 4'(c), t};
  endfunction
  task automatic send(input vec_t v);
    for (int k = 0; k < int'(v.n); k++) begin
      if (v.bub && $urandom_range(1) == 1) begin
        valid = 0;
        @(posedge clk); #1;
      end
      sel = v.sel;
      valid = 1;
      vote = v.votes[2*k +: 2];
      last = v.early && k == int'(v.n) - 1;
      @(posedge clk); #1;
    end
    valid = 0;
    last = 0;
  endtask
  task automatic result(input vec_t v, input string tag, input bit take);
    int lat = 0;
    while (!rv && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, v.sel ? 5 : 3);
    chk({tag, " winner"}, win, v.win);
    chk({tag, " count"}, cnt, v.cnt);
    chk({tag, " tie"}, tie, v.tie);
    if (take) begin
      rdy = 1;
      @(posedge clk); #1;
      rdy = 0;
      chk({tag, " ready after take"}, ir, 1);
      chk({tag, " valid after take"}, rv, 0);
    end
  endtask
  initial begin
    vec_t tbl [8];
    vec_t v;
    tbl[0] = mk(0, 0, 0, 8, 16'b01_00_01_00_00_01_01_01, 1, 5, 0);
    tbl[1] = mk(0, 0, 0, 8, 16'b01_00_01_00_01_00_01_00, 0, 4, 1);
    tbl[2] = mk(1, 1, 0, 3, 16'b00_00_00_00_00_10_11_10, 2, 2, 0);
    tbl[3] = mk(0, 0, 1, 8, 16'b01_00_01_00_00_01_01_01, 1, 5, 0);
    tbl[4] = mk(1, 0, 0, 8, 16'hffff, 3, 8, 0);
    tbl[5] = mk(1, 1, 0, 1, 16'h0000, 0, 1, 0);
    tbl[6] = mk(1, 1, 1, 4, 16'b00_00_00_00_01_01_11_11, 1, 2, 1);
    tbl[7] = mk(0, 1, 0, 8, 16'h0000, 0, 8, 0);
    #2;
    chk("reset res_valid", rv, 0);
    chk("reset in_ready", ir, 1);
    chk("reset winner", win, 0);
    chk("reset count", cnt, 0);
    chk("reset tie", tie, 0);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      send(tbl[i]);
      result(tbl[i], $sformatf("vec%0d", i), 1);
    end
    v = mk(0, 0, 0, 8, 16'h5555, 1, 8, 0);
    send(v);
    result(v, "bp frame", 0);
    for (int i = 0; i < 10; i++) begin
      valid = 1;
      vote = 0;
      @(posedge clk); #1;
      chk("bp in_ready", ir, 0);
      chk("bp res_valid", rv, 1);
      chk("bp winner", win, 1);
      chk("bp count", cnt, 8);
    end
    valid = 0;
    rdy = 1;
    @(posedge clk); #1;
    rdy = 0;
    chk("bp release ready", ir, 1);
    v = mk(0, 0, 0, 8, 16'h0000, 0, 8, 0);
    send(v);
    result(v, "bp next", 1);
    send(mk(0, 0, 0, 5, 16'h5555, 0, 0, 0));
    #3 rst = 1;
    #1;
    chk("async rst res_valid", rv, 0);
    chk("async rst in_ready", ir, 1);
    chk("async rst count", cnt, 0);
    rst = 0;
    last = 1;
    @(posedge clk); #1;
    last = 0;
    chk("stray last ignored", rv, 0);
    v = mk(0, 0, 1, 8, 16'b01_01_01_00_00_00_00_00, 0, 5, 0);
    send(v);
    result(v, "after rst", 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
